// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data cache address view, frame layout and FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int DC_SETS = 8;
  localparam int DC_IW   = $clog2(DC_SETS);
  localparam int DC_TAGW = 29 - DC_IW;

  typedef struct packed {
    logic [DC_TAGW-1:0] tag;
    logic [DC_IW-1:0]   idx;
    logic               blkoff;
    logic [1:0]         bytoff;
  } dcachef_t;

  // Tag field sized for the widest possible tag; narrower tags zero-extend.
  typedef struct packed {
    logic         valid;
    logic         dirty;
    logic [28:0]  tag;
    word_t [1:0]  word;
  } dcache_frame;

  typedef enum logic [2:0] {
    IDLE,
    WB0,
    WB1,
    LD0,
    LD1,
    FLUSH,
    COUNT,
    HALTED
  } dcache_state_t;

endpackage

// File: rtl/dcache_ctrl.sv
// Data cache controller: miss/flush FSM, flush walker, hit/miss counters.
module dcache_ctrl
  import cpu_types_pkg::*;
#(
  parameter int SETS = 8,
  parameter int IW   = $clog2(SETS)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          i_halt,
  input  logic          i_req,
  input  logic          i_hit,
  input  logic          i_vdirty,
  input  logic          i_fdirty,
  input  logic          i_dwait,
  output dcache_state_t o_state,
  output logic [IW-1:0] o_fidx,
  output logic          o_fword,
  output logic          o_dhit,
  output logic [31:0]   o_count
);

  dcache_state_t r_state, w_next;
  logic [IW-1:0] r_fidx;
  logic          r_fword;
  logic          r_pend;
  logic [31:0]   r_hits, r_misses;

  logic w_idle, w_halt_go, w_miss, w_last, w_fstep;

  // A just-filled request is served before halt can take over.
  assign w_idle    = (r_state == IDLE);
  assign w_halt_go = i_halt & ~(r_pend & i_req & i_hit);
  assign o_dhit    = w_idle & i_req & i_hit & ~w_halt_go;
  assign w_miss    = w_idle & i_req & ~i_hit & ~w_halt_go;
  assign w_last    = (r_fidx == IW'(SETS - 1));
  assign w_fstep   = (r_state == FLUSH) &
                     (~i_fdirty | (~i_dwait & r_fword));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_halt_go)
          w_next = FLUSH;
        else if (w_miss)
          w_next = i_vdirty ? WB0 : LD0;
      end
      WB0:    if (!i_dwait) w_next = WB1;
      WB1:    if (!i_dwait) w_next = LD0;
      LD0:    if (!i_dwait) w_next = LD1;
      LD1:    if (!i_dwait) w_next = IDLE;
      FLUSH:  if (w_fstep && w_last) w_next = COUNT;
      COUNT:  if (!i_dwait) w_next = HALTED;
      HALTED: w_next = HALTED;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_fidx   <= '0;
      r_fword  <= 1'b0;
      r_pend   <= 1'b0;
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      r_state  <= w_next;
      r_pend   <= (r_state == LD1) & ~i_dwait;
      r_hits   <= r_hits + 32'(o_dhit);
      r_misses <= r_misses + 32'(w_miss);
      if (w_idle)
        r_fidx <= '0;
      else if (w_fstep && !w_last)
        r_fidx <= r_fidx + 1'b1;
      if (w_idle)
        r_fword <= 1'b0;
      else if (r_state == FLUSH && i_fdirty && !i_dwait)
        r_fword <= ~r_fword;
    end
  end

  assign o_state = r_state;
  assign o_fidx  = r_fidx;
  assign o_fword = r_fword;
  assign o_count = r_hits - r_misses;

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped write-back L1 data cache with 2-word blocks.
module dcache_direct
  import cpu_types_pkg::*;
#(
  parameter int          SETS     = 8,
  parameter logic [31:0] CNT_ADDR = 32'h00003100
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 29 - IW;

  dcache_frame r_frames [SETS];

  dcache_state_t w_state;
  logic [TW-1:0] w_tag;
  logic [IW-1:0] w_idx, w_fidx;
  logic          w_off, w_fword;
  logic          w_req, w_hit, w_vdirty, w_fdirty;
  logic          w_dhit, w_wb1;
  logic [31:0]   w_count;
  logic [1:0]    w_unused_bytoff;

  assign w_tag  = dmemaddr[31:3+IW];
  assign w_idx  = dmemaddr[2+IW:3];
  assign w_off  = dmemaddr[2];
  assign w_req  = dmemREN | dmemWEN;
  assign w_unused_bytoff = dmemaddr[1:0];

  assign w_hit    = r_frames[w_idx].valid &
                    (r_frames[w_idx].tag == 29'(w_tag));
  assign w_vdirty = r_frames[w_idx].valid & r_frames[w_idx].dirty;
  assign w_fdirty = r_frames[w_fidx].valid & r_frames[w_fidx].dirty;

  dcache_ctrl #(.SETS(SETS)) u_ctrl (
    .CLK      (CLK),
    .nRST     (nRST),
    .i_halt   (halt),
    .i_req    (w_req),
    .i_hit    (w_hit),
    .i_vdirty (w_vdirty),
    .i_fdirty (w_fdirty),
    .i_dwait  (dwait),
    .o_state  (w_state),
    .o_fidx   (w_fidx),
    .o_fword  (w_fword),
    .o_dhit   (w_dhit),
    .o_count  (w_count)
  );

  assign dhit     = w_dhit;
  assign dmemload = w_dhit ? r_frames[w_idx].word[w_off] : '0;
  assign flushed  = (w_state == HALTED);
  assign w_wb1    = (w_state == WB1);

  always_comb begin
    dREN   = 1'b0;
    dWEN   = 1'b0;
    daddr  = '0;
    dstore = '0;
    case (w_state)
      WB0, WB1: begin
        dWEN   = 1'b1;
        daddr  = {r_frames[w_idx].tag[TW-1:0], w_idx, w_wb1, 2'b00};
        dstore = r_frames[w_idx].word[w_wb1];
      end
      LD0, LD1: begin
        dREN  = 1'b1;
        daddr = {w_tag, w_idx, w_state == LD1, 2'b00};
      end
      FLUSH: begin
        if (w_fdirty) begin
          dWEN   = 1'b1;
          daddr  = {r_frames[w_fidx].tag[TW-1:0], w_fidx,
                    w_fword, 2'b00};
          dstore = r_frames[w_fidx].word[w_fword];
        end
      end
      COUNT: begin
        dWEN   = 1'b1;
        daddr  = CNT_ADDR;
        dstore = w_count;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++)
        r_frames[i] <= '0;
    end else begin
      if (w_dhit && dmemWEN) begin
        r_frames[w_idx].word[w_off] <= dmemstore;
        r_frames[w_idx].dirty       <= 1'b1;
      end
      if (!dwait) begin
        case (w_state)
          WB1: r_frames[w_idx].dirty <= 1'b0;
          LD0: r_frames[w_idx].word[0] <= dload;
          LD1: begin
            r_frames[w_idx].word[1] <= dload;
            r_frames[w_idx].valid   <= 1'b1;
            r_frames[w_idx].tag     <= 29'(w_tag);
            r_frames[w_idx].dirty   <= 1'b0;
          end
          FLUSH: begin
            if (w_fdirty && w_fword)
              r_frames[w_fidx].dirty <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dcache_direct.sv
// Directed bench for dcache_direct with a fixed-latency memory model.
module tb_dcache_direct;

  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        halt;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit, flushed;
  logic [31:0] dmemload;
  logic        dREN, dWEN;
  logic [31:0] daddr, dstore, dload;
  logic        dwait;

  dcache_direct dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .halt      (halt),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .dhit      (dhit),
    .dmemload  (dmemload),
    .flushed   (flushed),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .dload     (dload),
    .dwait     (dwait)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;

  logic [31:0] mem [logic [31:0]];
  xfer_t       log_q [$];
  int          wcnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  assign dwait = (dREN | dWEN) && (wcnt < LAT);

  always @(negedge CLK)
    dload = mem.exists(daddr) ? mem[daddr] : 32'h0;

  always @(posedge CLK) begin
    if ((dREN || dWEN) && !dwait) begin
      log_q.push_back('{dWEN, daddr, dstore});
      if (dWEN) mem[daddr] = dstore;
    end
    if ((dREN || dWEN) && dwait) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_log(input int i, input logic w,
                           input logic [31:0] a,
                           input logic [31:0] d);
    if (i < log_q.size()) begin
      check($sformatf("log%0d_wen", i), 32'(log_q[i].w), 32'(w));
      check($sformatf("log%0d_addr", i), log_q[i].a, a);
      check($sformatf("log%0d_data", i), log_q[i].d, d);
    end else begin
      check($sformatf("log%0d_present", i), 32'd0, 32'd1);
    end
  endtask

  task automatic do_req(input logic r, input logic w,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input int halt_at,
                        output int lat,
                        output logic [31:0] data);
    dmemREN = r;
    dmemWEN = w;
    dmemaddr = a;
    dmemstore = d;
    lat = 0;
    data = '0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge CLK);
      if (dhit) begin
        lat = i;
        data = dmemload;
        break;
      end
      if (i == halt_at) halt = 1'b1;
    end
    @(posedge CLK);
    #1;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
  endtask

  task automatic check_idle_outs(input string pfx);
    check({pfx, "_dhit"}, 32'(dhit), 32'd0);
    check({pfx, "_dREN"}, 32'(dREN), 32'd0);
    check({pfx, "_dWEN"}, 32'(dWEN), 32'd0);
    check({pfx, "_daddr"}, daddr, 32'd0);
    check({pfx, "_dstore"}, dstore, 32'd0);
  endtask

  int          lat;
  logic [31:0] rd;
  int          bad;
  int          seen;

  initial begin
    nRST = 1'b0;
    halt = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    dmemaddr = '0;
    dmemstore = '0;
    mem[32'h100] = 32'hA;
    mem[32'h104] = 32'hB;
    mem[32'h140] = 32'hC;
    mem[32'h144] = 32'hD;

    repeat (2) @(negedge CLK);
    check_idle_outs("rst");
    check("rst_flushed", 32'(flushed), 32'd0);
    check("rst_dmemload", dmemload, 32'd0);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // cold read, clean victim: LD0 right after the miss cycle
    do_req(1, 0, 32'h100, 0, 0, lat, rd);
    check("cold_lat", 32'(lat), 32'd8);
    check("cold_data", rd, 32'hA);
    check("cold_nlog", 32'(log_q.size()), 32'd2);
    check_log(0, 0, 32'h100, 32'h0);
    check_log(1, 0, 32'h104, 32'h0);
    log_q.delete();

    do_req(1, 0, 32'h104, 0, 0, lat, rd);
    check("hit104_lat", 32'(lat), 32'd1);
    check("hit104_data", rd, 32'hB);

    do_req(0, 1, 32'h100, 32'h55, 0, lat, rd);
    check("wr100_lat", 32'(lat), 32'd1);

    // conflict on index 0 forces write-back of the dirty block
    do_req(1, 0, 32'h140, 0, 0, lat, rd);
    check("evict_lat", 32'(lat), 32'd14);
    check("evict_data", rd, 32'hC);
    check("evict_nlog", 32'(log_q.size()), 32'd4);
    check_log(0, 1, 32'h100, 32'h55);
    check_log(1, 1, 32'h104, 32'hB);
    check_log(2, 0, 32'h140, 32'h0);
    check_log(3, 0, 32'h144, 32'h0);
    log_q.delete();

    do_req(0, 1, 32'h010, 32'h22, 0, lat, rd);
    check("wr010_lat", 32'(lat), 32'd8);

    // halt raised during LD0: fill and its hit finish first
    do_req(0, 1, 32'h02C, 32'h66, 2, lat, rd);
    check("wr02c_halt_lat", 32'(lat), 32'd8);
    log_q.delete();

    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (flushed) begin
        seen = 1;
        break;
      end
    end
    check("flushed_seen", 32'(seen), 32'd1);
    check("flush_nlog", 32'(log_q.size()), 32'd5);
    check_log(0, 1, 32'h010, 32'h22);
    check_log(1, 1, 32'h014, 32'h0);
    check_log(2, 1, 32'h028, 32'h0);
    check_log(3, 1, 32'h02C, 32'h66);
    check_log(4, 1, 32'h3100, 32'd2);

    bad = 0;
    repeat (10) begin
      @(negedge CLK);
      if (!flushed || dhit || dREN || dWEN) bad++;
    end
    check("halted_stable", 32'(bad), 32'd0);
    check("halted_nlog", 32'(log_q.size()), 32'd5);

    // reset during WB1
    halt = 1'b0;
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    do_req(0, 1, 32'h100, 32'h77, 0, lat, rd);
    check("rwr100_lat", 32'(lat), 32'd8);
    dmemREN = 1'b1;
    dmemaddr = 32'h140;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (dWEN && daddr == 32'h104) begin
        seen = 1;
        break;
      end
    end
    check("wb1_seen", 32'(seen), 32'd1);
    nRST = 1'b0;
    #1;
    check_idle_outs("midrst");
    dmemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    do_req(1, 0, 32'h100, 0, 0, lat, rd);
    check("postrst_lat", 32'(lat), 32'd8);
    check("postrst_data", rd, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
